// File: rtl/tt_div_pkg.sv
// Shared definitions for the 8-bit by 4-bit restoring divider.
// Holds the FSM state encoding, iteration count, internal partial remainder
// width and the quotient value reported on divide-by-zero.
package tt_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One restoring step per dividend bit.
  localparam logic [3:0] ITER = 4'd8;

  // Partial remainder carries one extra bit so (R << 1 | bit) >= D never overflows.
  localparam int unsigned REM_W = 5;

  // Quotient reported when the divisor is zero.
  localparam logic [7:0] DZ_QUOT = 8'hFF;

endpackage : tt_div_pkg

// File: rtl/div_step.sv
// Single combinational restoring-division step.
// Ports:
//   rem_i  partial remainder entering the step (always < D, so MSB is 0)
//   bit_i  next dividend bit, MSB-first
//   d_i    divisor
//   rem_o  partial remainder after the conditional subtract
//   q_o    quotient bit produced by this step
module div_step
  import tt_div_pkg::*;
(
  input  logic [REM_W-1:0] rem_i,
  input  logic             bit_i,
  input  logic [3:0]       d_i,
  output logic [REM_W-1:0] rem_o,
  output logic             q_o
);

  logic [REM_W-1:0] shifted_s;
  logic [REM_W-1:0] diff_s;
  logic             unused_rem_msb_s;

  // Incoming remainder is below D (<= 14), so its MSB never carries into the shift.
  assign shifted_s        = {rem_i[REM_W-2:0], bit_i};
  assign diff_s           = shifted_s - {1'b0, d_i};
  assign q_o              = (shifted_s >= {1'b0, d_i});
  assign rem_o            = q_o ? diff_s : shifted_s;
  assign unused_rem_msb_s = rem_i[REM_W-1];

endmodule : div_step

// File: rtl/tt_um_div.sv
// 8-bit / 4-bit sequential restoring divider (8 cycles per operation).
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   ena      powered indicator (unused)
//   ui_in    dividend N
//   uio_in   [3:0] divisor D, [4] start (edge detected), [5] sel, [7:6] unused
//   uo_out   quotient (sel=0) or zero-extended remainder (sel=1)
//   uio_out  [7] busy, [6] done, [5] divide-by-zero, [4:0] zero
//   uio_oe   fixed output enables for uio_out[7:5]
module tt_um_div
  import tt_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t           state_q, state_d;
  logic             start_q;
  logic [7:0]       n_q, n_d;        // dividend bits still to consume; quotient bits shift in at LSB
  logic [3:0]       d_q, d_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       q_res_q, q_res_d;
  logic [7:0]       r_res_q, r_res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             start_evt_s;
  logic [REM_W-1:0] step_rem_s;
  logic             step_q_s;
  logic             unused_ok_s;

  assign start_evt_s = uio_in[4] & ~start_q;
  assign unused_ok_s = &{1'b0, ena, uio_in[7:6]};

  div_step u_step (
    .rem_i (rem_q),
    .bit_i (n_q[7]),
    .d_i   (d_q),
    .rem_o (step_rem_s),
    .q_o   (step_q_s)
  );

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_res_d = q_res_q;
    r_res_d = r_res_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_evt_s) begin
          n_d     = ui_in;
          d_d     = uio_in[3:0];
          rem_d   = {REM_W{1'b0}};
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          dz_d    = 1'b0;
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (d_q == 4'd0) begin
          // n_q is still untouched on the first RUN edge, so it is the original N.
          q_res_d = DZ_QUOT;
          r_res_d = n_q;
          dz_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          rem_d = step_rem_s;
          n_d   = {n_q[6:0], step_q_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == (ITER - 4'd1)) begin
            q_res_d = {n_q[6:0], step_q_s};
            r_res_d = {{(8 - REM_W){1'b0}}, step_rem_s};
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, operand, result and start-edge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      n_q     <= 8'd0;
      d_q     <= 4'd0;
      rem_q   <= {REM_W{1'b0}};
      cnt_q   <= 4'd0;
      q_res_q <= 8'd0;
      r_res_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= uio_in[4];
      n_q     <= n_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_res_q <= q_res_d;
      r_res_q <= r_res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign uo_out  = uio_in[5] ? r_res_q : q_res_q;
  assign uio_out = {busy_q, done_q, dz_q, 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

endmodule : tt_um_div

// File: tb/tb_tt_um_div.sv
// Directed, table-driven bench for tt_um_div plus hand-written multi-cycle
// sequences (restart during RUN, reset mid-RUN) and an exhaustive sweep.
module tb_tt_um_div;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [1:0] hi_b;
  logic       sel_b;
  logic       start_b;
  logic [3:0] d_b;

  int n_cmp;
  int n_mis;
  int sweep_prints;

  assign uio_in = {hi_b, sel_b, start_b, d_b};

  tt_um_div dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    logic [3:0] d;
    logic [1:0] hi;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start with the given operands, then wait (bounded) for done.
  task automatic run_op(input logic [7:0] n, input logic [3:0] d, input logic [1:0] hi,
                        output logic [7:0] gq, output logic [7:0] gr, output logic gdz,
                        output logic gbusy, output int lat,
                        output logic cap_busy, output logic [7:0] cap_q);
    ui_in   = n;
    d_b     = d;
    hi_b    = hi;
    sel_b   = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b  = 1'b0;
    cap_busy = uio_out[7];
    cap_q    = uo_out;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (uio_out[6]) begin
        lat = c;
        break;
      end
    end
    gq    = uo_out;
    gdz   = uio_out[5];
    gbusy = uio_out[7];
    sel_b = 1'b1;
    #1;
    gr    = uo_out;
    sel_b = 1'b0;
    #1;
  endtask

  initial begin
    vec_t vecs[10];
    logic [7:0] gq, gr, cap_q, prev_q;
    logic       gdz, gbusy, cap_busy;
    int         lat;
    logic [7:0] eq, er;

    n_cmp = 0;
    n_mis = 0;
    sweep_prints = 0;

    vecs[0] = '{8'd200, 4'd7,  2'b00, 8'd28,  8'd4,  1'b0, 8};
    vecs[1] = '{8'd255, 4'd1,  2'b11, 8'd255, 8'd0,  1'b0, 8};
    vecs[2] = '{8'd3,   4'd15, 2'b10, 8'd0,   8'd3,  1'b0, 8};
    vecs[3] = '{8'd5,   4'd0,  2'b00, 8'hFF,  8'h05, 1'b1, 1};
    vecs[4] = '{8'd0,   4'd5,  2'b01, 8'd0,   8'd0,  1'b0, 8};
    vecs[5] = '{8'd64,  4'd8,  2'b00, 8'd8,   8'd0,  1'b0, 8};
    vecs[6] = '{8'd15,  4'd15, 2'b11, 8'd1,   8'd0,  1'b0, 8};
    vecs[7] = '{8'd254, 4'd15, 2'b00, 8'd16,  8'd14, 1'b0, 8};
    vecs[8] = '{8'd128, 4'd3,  2'b10, 8'd42,  8'd2,  1'b0, 8};
    vecs[9] = '{8'd200, 4'd0,  2'b01, 8'hFF,  8'd200, 1'b1, 1};

    rst_n = 1'b0; ena = 1'b1; ui_in = 8'd0;
    hi_b = 2'b00; sel_b = 1'b0; start_b = 1'b0; d_b = 4'd0;

    // Reset state
    #12;
    check("reset_uo_out", uo_out, 8'd0);
    check("reset_uio_out", uio_out, 8'd0);
    check("uio_oe", uio_oe, 8'hE0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_uio_out", uio_out, 8'd0);

    // Table-driven vectors
    prev_q = 8'd0;
    foreach (vecs[i]) begin
      run_op(vecs[i].n, vecs[i].d, vecs[i].hi, gq, gr, gdz, gbusy, lat, cap_busy, cap_q);
      check($sformatf("v%0d_busy_at_start", i), cap_busy, 1'b1);
      check($sformatf("v%0d_q_held", i), cap_q, prev_q);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_q", i), gq, vecs[i].q);
      check($sformatf("v%0d_r", i), gr, vecs[i].r);
      check($sformatf("v%0d_dz", i), gdz, vecs[i].dz);
      check($sformatf("v%0d_busy_end", i), gbusy, 1'b0);
      prev_q = vecs[i].q;
    end

    // Results hold in DONE
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", uo_out, prev_q);
    check("hold_done", uio_out[6], 1'b1);

    // Restart during RUN is ignored: 100/9 must complete on schedule
    ui_in = 8'd100; d_b = 4'd9; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ui_in = 8'd10; d_b = 4'd2; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("rerun_busy", uio_out[7], 1'b1);
    lat = 0;
    for (int c = 4; c <= 20; c++) begin
      @(posedge clk); #1;
      if (uio_out[6]) begin
        lat = c;
        break;
      end
    end
    check("rerun_latency", lat, 8);
    check("rerun_q", uo_out, 8'd11);
    sel_b = 1'b1; #1;
    check("rerun_r", uo_out, 8'd1);
    sel_b = 1'b0; #1;

    // Reset mid-RUN, then start held through reset release
    ui_in = 8'd200; d_b = 4'd7; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_uo_q", uo_out, 8'd0);
    check("abort_uio_out", uio_out, 8'd0);
    sel_b = 1'b1; #1;
    check("abort_uo_r", uo_out, 8'd0);
    sel_b = 1'b0;
    ui_in = 8'd64; d_b = 4'd8; start_b = 1'b1;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("post_reset_start_busy", uio_out[7], 1'b1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (uio_out[6]) begin
        lat = c;
        break;
      end
    end
    check("post_reset_latency", lat, 8);
    check("post_reset_q", uo_out, 8'd8);
    sel_b = 1'b1; #1;
    check("post_reset_r", uo_out, 8'd0);
    sel_b = 1'b0; #1;

    // Exhaustive sweep, back-to-back from DONE
    for (int n = 0; n < 256; n++) begin
      for (int d = 1; d < 16; d++) begin
        run_op(8'(n), 4'(d), 2'(n), gq, gr, gdz, gbusy, lat, cap_busy, cap_q);
        eq = 8'(n / d);
        er = 8'(n % d);
        n_cmp++;
        if (gq !== eq || gr !== er || lat != 8 || gdz !== 1'b0) begin
          n_mis++;
          if (sweep_prints < 10) begin
            sweep_prints++;
            $display("FAIL sweep n=%0d d=%0d: got q=%0d r=%0d lat=%0d dz=%0b expected q=%0d r=%0d lat=8 dz=0",
                     n, d, gq, gr, lat, gdz, eq, er);
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_tt_um_div
